// File: rtl/sd_resp_receiver.sv
// SPI-mode SD card reply receiver.
// Once armed it hunts for and deserialises an R1 (8 bit), R7 (40 bit) or a
// 512-byte read data block with trailing CRC16, and presents the reply
// right-aligned in a 4096-bit word together with a one-cycle valid strobe.
//
// Ports:
//   clock          system clock, all state changes on the rising edge
//   reset          synchronous active-high reset
//   arm            one-cycle strobe: latch response_type, clear outputs, start hunting
//   response_type  00 R1, 01 R7, 10 data block, 11 treated as R1
//   miso           serial data from the card, MSB first, idles high
//   received_data  deserialised reply, right-aligned
//   data_valid     one-cycle pulse when a reply or timeout completes
//   crc_error      data-block CRC mismatch, valid with data_valid
//   timeout        hunt expired before a start bit or token arrived, valid with data_valid
//   receiving      high in any state other than IDLE
module sd_resp_receiver #(
   parameter int unsigned RESP_TIMEOUT_BITS    = 64,
   parameter int unsigned TOKEN_TIMEOUT_CYCLES = 100000
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          arm,
   input  logic [1:0]    response_type,
   input  logic          miso,
   output logic [4095:0] received_data,
   output logic          data_valid,
   output logic          crc_error,
   output logic          timeout,
   output logic          receiving
);

   localparam int unsigned DATA_W     = 4096;
   localparam int unsigned BIT_CNT_W  = 13;
   localparam int unsigned HUNT_CNT_W = 17;
   localparam int unsigned CRC_W      = 16;

   localparam logic [HUNT_CNT_W-1:0] HUNT_MAX   = '1;
   localparam logic [BIT_CNT_W-1:0]  LAST_DATA  = BIT_CNT_W'(DATA_W - 1);
   localparam logic [BIT_CNT_W-1:0]  LAST_CRC   = BIT_CNT_W'(CRC_W - 1);
   localparam logic [CRC_W-1:0]      CRC_POLY   = 16'h1021;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HUNT_RESP,
      S_SHIFT_RESP,
      S_HUNT_TOKEN,
      S_SHIFT_DATA,
      S_SHIFT_CRC,
      S_DONE
   } state_e;

   state_e                state_q, state_d;
   logic                  is_r7_q, is_r7_d;
   logic [DATA_W-1:0]     data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  crc_err_q, crc_err_d;
   logic                  tmo_q, tmo_d;
   logic                  recv_q, recv_d;
   logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [HUNT_CNT_W-1:0] hunt_cnt_q, hunt_cnt_d;
   logic [7:0]            window_q, window_d;
   logic [CRC_W-1:0]      crc_q, crc_d;
   logic [CRC_W-1:0]      crc_rx_q, crc_rx_d;

   // Shared shift/count helpers for the current miso sample
   logic [HUNT_CNT_W-1:0] hunt_inc;
   logic [7:0]            window_shift;
   logic [DATA_W-1:0]     data_shift;
   logic [CRC_W-1:0]      crc_next;
   logic [CRC_W-1:0]      crc_rx_shift;
   logic [BIT_CNT_W-1:0]  resp_len;

   always_comb begin
      hunt_inc     = (hunt_cnt_q == HUNT_MAX) ? hunt_cnt_q : hunt_cnt_q + HUNT_CNT_W'(1);
      window_shift = {window_q[6:0], miso};
      data_shift   = {data_q[DATA_W-2:0], miso};
      crc_next     = {crc_q[CRC_W-2:0], 1'b0} ^ ((crc_q[CRC_W-1] ^ miso) ? CRC_POLY : '0);
      crc_rx_shift = {crc_rx_q[CRC_W-2:0], miso};
      resp_len     = is_r7_q ? BIT_CNT_W'(40) : BIT_CNT_W'(8);
   end

   // Next-state and output logic
   always_comb begin
      state_d    = state_q;
      is_r7_d    = is_r7_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      crc_err_d  = crc_err_q;
      tmo_d      = tmo_q;
      bit_cnt_d  = bit_cnt_q;
      hunt_cnt_d = hunt_cnt_q;
      window_d   = window_q;
      crc_d      = crc_q;
      crc_rx_d   = crc_rx_q;

      if (arm) begin
         // arm restarts from scratch, aborting any reception in flight
         is_r7_d    = (response_type == 2'b01);
         data_d     = '0;
         crc_err_d  = 1'b0;
         tmo_d      = 1'b0;
         bit_cnt_d  = '0;
         hunt_cnt_d = '0;
         window_d   = '0;
         crc_d      = '0;
         crc_rx_d   = '0;
         state_d    = (response_type == 2'b10) ? S_HUNT_TOKEN : S_HUNT_RESP;
      end else begin
         unique case (state_q)
            S_HUNT_RESP: begin
               if (!miso) begin
                  data_d    = data_shift;
                  bit_cnt_d = BIT_CNT_W'(1);
                  state_d   = S_SHIFT_RESP;
               end else begin
                  hunt_cnt_d = hunt_inc;
                  if (hunt_inc >= HUNT_CNT_W'(RESP_TIMEOUT_BITS)) begin
                     data_d[7:0] = 8'hFF;
                     tmo_d       = 1'b1;
                     valid_d     = 1'b1;
                     state_d     = S_DONE;
                  end
               end
            end
            S_SHIFT_RESP: begin
               data_d    = data_shift;
               bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               if (bit_cnt_d == resp_len) begin
                  valid_d = 1'b1;
                  state_d = S_DONE;
               end
            end
            S_HUNT_TOKEN: begin
               // hunt_cnt counts cycles since arm; it also gates the error-token
               // match so the cleared window cannot fake an all-zero nibble
               window_d   = window_shift;
               hunt_cnt_d = hunt_inc;
               if (window_shift == 8'hFE) begin
                  bit_cnt_d = '0;
                  crc_d     = '0;
                  state_d   = S_SHIFT_DATA;
               end else if (window_shift[7:4] == 4'h0 && hunt_inc >= HUNT_CNT_W'(8)) begin
                  data_d[7:0] = window_shift;
                  valid_d     = 1'b1;
                  state_d     = S_DONE;
               end else if (hunt_inc >= HUNT_CNT_W'(TOKEN_TIMEOUT_CYCLES)) begin
                  data_d[7:0] = 8'hFF;
                  tmo_d       = 1'b1;
                  valid_d     = 1'b1;
                  state_d     = S_DONE;
               end
            end
            S_SHIFT_DATA: begin
               data_d = data_shift;
               crc_d  = crc_next;
               if (bit_cnt_q == LAST_DATA) begin
                  bit_cnt_d = '0;
                  state_d   = S_SHIFT_CRC;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               end
            end
            S_SHIFT_CRC: begin
               crc_rx_d = crc_rx_shift;
               if (bit_cnt_q == LAST_CRC) begin
                  crc_err_d = (crc_rx_shift != crc_q);
                  valid_d   = 1'b1;
                  state_d   = S_DONE;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end

      recv_d = (state_d != S_IDLE);
   end

   // State and output registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         is_r7_q    <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         crc_err_q  <= 1'b0;
         tmo_q      <= 1'b0;
         recv_q     <= 1'b0;
         bit_cnt_q  <= '0;
         hunt_cnt_q <= '0;
         window_q   <= '0;
         crc_q      <= '0;
         crc_rx_q   <= '0;
      end else begin
         state_q    <= state_d;
         is_r7_q    <= is_r7_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         crc_err_q  <= crc_err_d;
         tmo_q      <= tmo_d;
         recv_q     <= recv_d;
         bit_cnt_q  <= bit_cnt_d;
         hunt_cnt_q <= hunt_cnt_d;
         window_q   <= window_d;
         crc_q      <= crc_d;
         crc_rx_q   <= crc_rx_d;
      end
   end

   assign received_data = data_q;
   assign data_valid    = valid_q;
   assign crc_error     = crc_err_q;
   assign timeout       = tmo_q;
   assign receiving     = recv_q;

endmodule

// File: tb/tb_sd_resp_receiver.sv
// Testbench for sd_resp_receiver: table vectors for R1/R7/timeout/error-token
// cases, hand-written data-block, abort and reset sequences, and randomized
// replies checked against a bit-stream reference model.
module tb_sd_resp_receiver;

   localparam int unsigned DW = 4096;

   logic          clock = 1'b0;
   logic          reset;
   logic          arm;
   logic [1:0]    response_type;
   logic          miso;
   logic [DW-1:0] received_data;
   logic          data_valid;
   logic          crc_error;
   logic          timeout;
   logic          receiving;

   sd_resp_receiver dut (
      .clock         (clock),
      .reset         (reset),
      .arm           (arm),
      .response_type (response_type),
      .miso          (miso),
      .received_data (received_data),
      .data_valid    (data_valid),
      .crc_error     (crc_error),
      .timeout       (timeout),
      .receiving     (receiving)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Bits driven on miso after the arm cycle, index i sampled on the i-th edge
   bit stim[$];

   int            nvalid;
   int            valid_bit;
   logic [DW-1:0] got_data;
   logic          got_crc;
   logic          got_tmo;
   logic          got_recv;

   typedef struct {
      logic [DW-1:0] data;
      logic          crc_err;
      logic          tmo;
      int            done_bit;
   } exp_t;

   typedef struct {
      logic [1:0]  typ;
      int          prefix;
      int          len;
      logic [39:0] resp;
      logic [39:0] exp_data;
      logic        exp_tmo;
      int          exp_done;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic chk_wide(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      int first;
      checks++;
      if (act !== req) begin
         errors++;
         first = -1;
         for (int i = DW - 1; i >= 0; i--)
            if (act[i] !== req[i] && first < 0) first = i;
         $display("FAIL %s first_diff_bit=%0d actual[4095:4032]=%h required[4095:4032]=%h actual[63:0]=%h required[63:0]=%h",
                  name, first, act[DW-1 -: 64], req[DW-1 -: 64], act[63:0], req[63:0]);
      end
   endtask

   function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c ^ {b, 8'h00};
      for (int i = 0; i < 8; i++)
         r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
      return r;
   endfunction

   task automatic push_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) stim.push_back(b[i]);
   endtask

   task automatic push_ones(input int n);
      for (int i = 0; i < n; i++) stim.push_back(1'b1);
   endtask

   task automatic push_bits(input logic [39:0] v, input int len);
      for (int i = len - 1; i >= 0; i--) stim.push_back(v[i]);
   endtask

   // Reference model: reads the reply straight off the bit stream
   function automatic exp_t model(input logic [1:0] typ);
      exp_t        e;
      int          n;
      int          k;
      int          len;
      int          p;
      logic [7:0]  w;
      logic [15:0] calc;
      logic [15:0] rx;
      e.data     = '0;
      e.crc_err  = 1'b0;
      e.tmo      = 1'b0;
      e.done_bit = -1;
      n          = stim.size();
      if (typ != 2'b10) begin
         len = (typ == 2'b01) ? 40 : 8;
         k   = -1;
         for (int i = 0; i < n && i < 64; i++)
            if (stim[i] == 1'b0 && k < 0) k = i;
         if (k < 0) begin
            if (n >= 64) begin
               e.data[7:0] = 8'hFF;
               e.tmo       = 1'b1;
               e.done_bit  = 63;
            end
         end else if (k + len <= n) begin
            for (int j = 0; j < len; j++) e.data[len-1-j] = stim[k+j];
            e.done_bit = k + len - 1;
         end
      end else begin
         p = -1;
         for (int i = 7; i < n && p < 0 && e.done_bit < 0; i++) begin
            for (int b = 0; b < 8; b++) w[7-b] = stim[i-7+b];
            if (w == 8'hFE) begin
               p = i;
            end else if (w[7:4] == 4'h0) begin
               e.data[7:0] = w;
               e.done_bit  = i;
            end
         end
         if (p >= 0 && p + 4112 < n) begin
            for (int b = 0; b < 4096; b++) e.data[DW-1-b] = stim[p+1+b];
            calc = 16'h0000;
            for (int j = 0; j < 512; j++) calc = crc_byte(calc, e.data[DW-1-8*j -: 8]);
            for (int b = 0; b < 16; b++) rx[15-b] = stim[p+4097+b];
            e.crc_err  = (rx != calc);
            e.done_bit = p + 4112;
         end
      end
      return e;
   endfunction

   // Arm, drive stim plus tail idle-high bits, record valid pulses and final outputs
   task automatic apply(input logic [1:0] typ, input int tail);
      int n;
      nvalid    = 0;
      valid_bit = -1;
      n         = stim.size();
      @(negedge clock);
      arm           = 1'b1;
      response_type = typ;
      miso          = 1'b1;
      @(negedge clock);
      arm = 1'b0;
      for (int i = 0; i < n + tail; i++) begin
         miso = (i < n) ? stim[i] : 1'b1;
         @(negedge clock);
         if (data_valid === 1'b1) begin
            nvalid++;
            if (valid_bit < 0) valid_bit = i;
         end
      end
      got_data = received_data;
      got_crc  = crc_error;
      got_tmo  = timeout;
      got_recv = receiving;
   endtask

   task automatic check_model(input string tag, input exp_t e);
      chk_wide({tag, "_data"}, got_data, e.data);
      chk({tag, "_crc"}, 64'(got_crc), 64'(e.crc_err));
      chk({tag, "_tmo"}, 64'(got_tmo), 64'(e.tmo));
      chk({tag, "_nvalid"}, 64'(nvalid), 64'(1));
      chk({tag, "_done_bit"}, 64'(valid_bit), 64'(e.done_bit));
      chk({tag, "_recv_idle"}, 64'(got_recv), 64'(0));
   endtask

   task automatic build_block(input logic random_bytes, input int prefix);
      logic [7:0]  b;
      logic [15:0] c;
      stim.delete();
      push_ones(prefix);
      push_byte(8'hFE);
      c = 16'h0000;
      for (int i = 0; i < 512; i++) begin
         b = random_bytes ? 8'($urandom) : 8'(i % 256);
         push_byte(b);
         c = crc_byte(c, b);
      end
      push_byte(c[15:8]);
      push_byte(c[7:0]);
   endtask

   initial begin
      exp_t          e;
      logic [DW-1:0] good_data;
      logic [39:0]   r;
      logic [1:0]    typ;
      int            len;
      int            pre;
      int            idx;

      vecs[0] = '{typ: 2'b00, prefix: 24, len: 8,  resp: 40'h01,         exp_data: 40'h01,         exp_tmo: 1'b0, exp_done: 31};
      vecs[1] = '{typ: 2'b01, prefix: 8,  len: 40, resp: 40'h01000001AA, exp_data: 40'h01000001AA, exp_tmo: 1'b0, exp_done: 47};
      vecs[2] = '{typ: 2'b11, prefix: 0,  len: 8,  resp: 40'h05,         exp_data: 40'h05,         exp_tmo: 1'b0, exp_done: 7};
      vecs[3] = '{typ: 2'b00, prefix: 64, len: 0,  resp: 40'h00,         exp_data: 40'hFF,         exp_tmo: 1'b1, exp_done: 63};
      vecs[4] = '{typ: 2'b00, prefix: 63, len: 8,  resp: 40'h00,         exp_data: 40'h00,         exp_tmo: 1'b0, exp_done: 70};
      vecs[5] = '{typ: 2'b01, prefix: 3,  len: 40, resp: 40'h7FFFFFFF80, exp_data: 40'h7FFFFFFF80, exp_tmo: 1'b0, exp_done: 42};
      vecs[6] = '{typ: 2'b10, prefix: 0,  len: 8,  resp: 40'h08,         exp_data: 40'h08,         exp_tmo: 1'b0, exp_done: 7};

      reset         = 1'b1;
      arm           = 1'b0;
      response_type = 2'b00;
      miso          = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk_wide("reset_data", received_data, '0);
      chk("reset_valid", 64'(data_valid), 64'(0));
      chk("reset_crc", 64'(crc_error), 64'(0));
      chk("reset_tmo", 64'(timeout), 64'(0));
      chk("reset_recv", 64'(receiving), 64'(0));

      // Table-driven replies
      for (int v = 0; v < 7; v++) begin
         stim.delete();
         push_ones(vecs[v].prefix);
         push_bits(vecs[v].resp, vecs[v].len);
         apply(vecs[v].typ, 4);
         chk_wide($sformatf("vec%0d_data", v), got_data, DW'(vecs[v].exp_data));
         chk($sformatf("vec%0d_tmo", v), 64'(got_tmo), 64'(vecs[v].exp_tmo));
         chk($sformatf("vec%0d_crc", v), 64'(got_crc), 64'(0));
         chk($sformatf("vec%0d_nvalid", v), 64'(nvalid), 64'(1));
         chk($sformatf("vec%0d_done_bit", v), 64'(valid_bit), 64'(vecs[v].exp_done));
         chk($sformatf("vec%0d_recv_idle", v), 64'(got_recv), 64'(0));
      end

      // Data block with good CRC
      build_block(1'b0, 80);
      e = model(2'b10);
      apply(2'b10, 4);
      check_model("blk_good", e);
      chk("blk_good_first_byte", 64'(got_data[DW-1 -: 8]), 64'(8'h00));
      chk("blk_good_last_byte", 64'(got_data[7:0]), 64'(8'hFF));
      chk("blk_good_done_abs", 64'(valid_bit), 64'(4199));
      good_data = got_data;

      // Same block, last CRC bit flipped
      idx       = stim.size() - 1;
      stim[idx] = ~stim[idx];
      e         = model(2'b10);
      apply(2'b10, 4);
      check_model("blk_bad", e);
      chk("blk_bad_crc_const", 64'(got_crc), 64'(1));
      chk_wide("blk_bad_data_same", got_data, good_data);

      // Abort a data block by re-arming for an R1
      stim.delete();
      push_ones(16);
      push_byte(8'hFE);
      for (int i = 0; i < 25; i++) push_byte(8'(i * 7));
      apply(2'b10, 0);
      chk("abort_no_valid", 64'(nvalid), 64'(0));
      chk("abort_recv_mid", 64'(got_recv), 64'(1));
      stim.delete();
      push_byte(8'h05);
      push_ones(8);
      apply(2'b00, 4);
      chk("abort_nvalid", 64'(nvalid), 64'(1));
      chk_wide("abort_data", got_data, DW'(8'h05));
      chk("abort_tmo", 64'(got_tmo), 64'(0));

      // Synchronous reset in the middle of a data block
      stim.delete();
      push_byte(8'hFE);
      for (int i = 0; i < 100; i++) push_byte(8'hA5);
      apply(2'b10, 0);
      chk("rst_mid_recv_before", 64'(receiving), 64'(1));
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk_wide("rst_mid_data", received_data, '0);
      chk("rst_mid_valid", 64'(data_valid), 64'(0));
      chk("rst_mid_crc", 64'(crc_error), 64'(0));
      chk("rst_mid_tmo", 64'(timeout), 64'(0));
      chk("rst_mid_recv", 64'(receiving), 64'(0));
      for (int i = 0; i < 20; i++) begin
         miso = 1'($urandom);
         @(negedge clock);
      end
      chk("idle_ignores_miso", 64'(receiving), 64'(0));
      chk_wide("idle_data_zero", received_data, '0);

      // Randomized R1/R7 replies, including hunt timeouts
      for (int t = 0; t < 24; t++) begin
         typ = 2'($urandom_range(0, 3));
         if (typ == 2'b10) typ = 2'b11;
         len = (typ == 2'b01) ? 40 : 8;
         pre = $urandom_range(0, 70);
         r   = {8'($urandom), 32'($urandom)};
         r[len-1] = 1'b0;
         stim.delete();
         push_ones(pre);
         push_bits(r, len);
         e = model(typ);
         apply(typ, 4);
         check_model($sformatf("rnd_resp%0d", t), e);
      end

      // Randomized error tokens straight after arm
      for (int t = 0; t < 4; t++) begin
         stim.delete();
         push_byte(8'($urandom_range(0, 15)));
         push_ones(8);
         e = model(2'b10);
         apply(2'b10, 4);
         check_model($sformatf("rnd_tok%0d", t), e);
      end

      // Randomized data blocks, CRC randomly corrupted
      for (int t = 0; t < 2; t++) begin
         build_block(1'b1, $urandom_range(0, 30));
         if ($urandom_range(0, 1) == 1) begin
            idx       = stim.size() - 1 - $urandom_range(0, 15);
            stim[idx] = ~stim[idx];
         end
         e = model(2'b10);
         apply(2'b10, 4);
         check_model($sformatf("rnd_blk%0d", t), e);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
